// File: rtl/bus_pkg.sv
// Shared types for the byte bus: sender, receiver and the bus_if interface.
package bus_pkg;

  localparam int unsigned BUS_DATA_W = 8;

  typedef logic [BUS_DATA_W-1:0] bus_byte_t;

endpackage

// File: rtl/bus_if.sv
// Byte bus with a valid/ready handshake; the sender holds data/valid until ready is seen.
interface bus_if
  import bus_pkg::*;
(
  input logic clk
);

  bus_byte_t data;
  logic      valid;
  logic      ready;

  modport master (
    input  clk,
    input  ready,
    output data,
    output valid
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );

endinterface

// File: rtl/bus_fifo_core.sv
// First-word-fall-through FIFO: memory, pointers and occupancy level.
module bus_fifo_core
  import bus_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter type         data_t = bus_byte_t
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  data_t                    wdata,
  input  logic                     pop,
  output data_t                    rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  data_t          mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [LW-1:0]  level_q;
  logic [LW-1:0]  level_d;
  logic           push_fire;
  logic           pop_fire;

  assign full      = (level_q == LW'(DEPTH));
  assign empty     = (level_q == '0);
  assign push_fire = push && !full;
  assign pop_fire  = pop && !empty;
  assign level     = level_q;
  // Head is forced to zero while empty so the unreset memory never leaks out.
  assign rdata     = empty ? data_t'(0) : mem_q[rd_ptr_q];

  always_comb begin
    level_d = level_q;
    unique case ({push_fire, pop_fire})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_fire) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_fire)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/bus_rx_fifo.sv
// Slave-side receive buffer: accepts bus bytes into a FWFT FIFO and exposes a pop port.
module bus_rx_fifo
  import bus_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned AFULL_THRESH = 6,
  parameter int unsigned STALL_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bus_if.slave                   bus,
  output bus_byte_t              m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   almost_full,
  output logic [STALL_W-1:0]     stall_cnt
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic               ready_en_q;
  logic               almost_full_q;
  logic [STALL_W-1:0] stall_cnt_q;
  logic [LW-1:0]      level_d;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  // Ready depends only on registers; a pop at full does not reopen it until the next cycle.
  assign bus.ready   = ready_en_q && !full;
  assign push        = bus.valid && bus.ready;
  assign pop         = m_ready && !empty;
  assign m_valid     = !empty;
  assign almost_full = almost_full_q;
  assign stall_cnt   = stall_cnt_q;

  bus_fifo_core #(
    .DEPTH  (DEPTH),
    .data_t (bus_byte_t)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (bus.data),
    .pop   (pop),
    .rdata (m_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_comb begin
    level_d = level;
    if (push && !pop) begin
      level_d = level + LW'(1);
    end else if (!push && pop) begin
      level_d = level - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q    <= 1'b0;
      almost_full_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      ready_en_q    <= 1'b1;
      almost_full_q <= (level_d >= LW'(AFULL_THRESH));
      if (bus.valid && !bus.ready && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + STALL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bus_rx_fifo.sv
// Directed self-checking bench for bus_rx_fifo with hand-computed expectations.
module tb_bus_rx_fifo;
  import bus_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        m_ready;
  bus_byte_t   m_data;
  logic        m_valid;
  logic [3:0]  level;
  logic        almost_full;
  logic [15:0] stall_cnt;

  int n_checks;
  int n_errors;

  bus_if u_bus (.clk(clk));

  bus_rx_fifo #(
    .DEPTH        (8),
    .AFULL_THRESH (6),
    .STALL_W      (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (u_bus.slave),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .level       (level),
    .almost_full (almost_full),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst_n        = 1'b0;
    m_ready      = 1'b0;
    u_bus.valid  = 1'b0;
    u_bus.data   = 8'h00;
    tick();
    tick();

    check("reset level", level, 0);
    check("reset m_valid", m_valid, 0);
    check("reset m_data", m_data, 0);
    check("reset ready", u_bus.ready, 0);
    check("reset afull", almost_full, 0);
    check("reset stall", stall_cnt, 0);

    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("ready after release", u_bus.ready, 1);

    // Single byte
    u_bus.data  = 8'hAB;
    u_bus.valid = 1'b1;
    tick();
    u_bus.valid = 1'b0;
    check("single level", level, 1);
    check("single m_valid", m_valid, 1);
    check("single m_data", m_data, 8'hAB);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("single pop level", level, 0);
    check("single pop m_valid", m_valid, 0);

    // Fill to full
    for (int i = 1; i <= 8; i++) begin
      u_bus.data  = 8'(i);
      u_bus.valid = 1'b1;
      tick();
      check($sformatf("fill level %0d", i), level, i);
      check($sformatf("fill afull %0d", i), almost_full, (i >= 6) ? 1 : 0);
    end
    check("full ready", u_bus.ready, 0);
    u_bus.data = 8'h09;
    tick();
    tick();
    tick();
    check("full stall", stall_cnt, 3);
    check("full level hold", level, 8);
    check("full head", m_data, 8'h01);

    // Pop at full with a push attempt in the same cycle
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("pop at full level", level, 7);
    check("pop at full stall", stall_cnt, 4);
    check("pop at full ready", u_bus.ready, 1);
    check("pop at full afull", almost_full, 1);
    check("pop at full head", m_data, 8'h02);
    tick();
    u_bus.valid = 1'b0;
    check("refill level", level, 8);
    check("refill stall", stall_cnt, 4);

    // Drain and confirm order, including the late 8'h09
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain data %0d", k), m_data, 8'h02 + k);
      m_ready = 1'b1;
      tick();
    end
    m_ready = 1'b0;
    check("drain level", level, 0);
    check("drain afull", almost_full, 0);

    // Streaming with continuous pop
    m_ready     = 1'b1;
    u_bus.valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      u_bus.data = 8'h10 + 8'(i);
      tick();
      check($sformatf("stream level %0d", i), level, 1);
      check($sformatf("stream data %0d", i), m_data, 8'h10 + i);
    end
    u_bus.valid = 1'b0;
    tick();
    check("stream drain level", level, 0);
    check("stream stall", stall_cnt, 4);

    // Pop on empty must not move the read pointer
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("empty pop level %0d", i), level, 0);
    end
    m_ready     = 1'b0;
    u_bus.data  = 8'h77;
    u_bus.valid = 1'b1;
    tick();
    u_bus.valid = 1'b0;
    check("after empty pop data", m_data, 8'h77);
    check("after empty pop level", level, 1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("after empty pop drain", level, 0);

    // Reset mid-operation
    u_bus.valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      u_bus.data = 8'h31 + 8'(i);
      tick();
    end
    check("pre-reset level", level, 5);
    u_bus.data = 8'h5A;
    #3;
    rst_n = 1'b0;
    #1;
    check("mid reset m_valid", m_valid, 0);
    check("mid reset level", level, 0);
    check("mid reset ready", u_bus.ready, 0);
    check("mid reset stall", stall_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("re-release ready", u_bus.ready, 1);
    check("re-release stall", stall_cnt, 1);
    check("re-release level", level, 0);
    tick();
    u_bus.valid = 1'b0;
    check("post-reset data", m_data, 8'h5A);
    check("post-reset level", level, 1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("post-reset drain", level, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
